// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds FSM state encoding, queue depth and default geometry.
package fetch_ctrl_pkg;

    localparam int QDEPTH        = 2;
    localparam int DEF_PC_W      = 32;
    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_RESET_PC  = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-decode instruction handshake.
// The fetch side is the master; decode is the slave.
interface fetch_ctrl_if #(
    parameter int PC_W = 32
);

    logic            inst_valid;
    logic [31:0]     inst_data;
    logic [PC_W-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_ctrl_queue.sv
// Two-entry prefetch FIFO of {instruction, pc}.
// Flush wins over push and pop in the same cycle.
module fetch_ctrl_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [31:0]     push_data_i,
    input  logic [PC_W-1:0] push_pc_i,
    output logic [31:0]     head_data_o,
    output logic [PC_W-1:0] head_pc_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [1:0]      count_o
);

    logic [31:0]     data_q [QDEPTH];
    logic [PC_W-1:0] pc_q   [QDEPTH];
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    // Qualify push/pop against occupancy and compute next pointers.
    always_comb begin
        do_pop  = pop_i && (cnt_q != 2'd0);
        do_push = push_i && ((cnt_q < 2'(QDEPTH)) || do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            data_q[wr_q] <= push_data_i;
            pc_q[wr_q]   <= push_pc_i;
        end
    end

    assign head_data_o = data_q[rd_q];
    assign head_pc_o   = pc_q[rd_q];
    assign full_o      = (cnt_q == 2'(QDEPTH));
    assign empty_o     = (cnt_q == 2'd0);
    assign count_o     = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, run/halt/fault FSM,
// prefetch queue control and a running fetch counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int RESET_PC  = DEF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pc_out,
    input  logic [31:0]     mem_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt_req,
    fetch_ctrl_if.master    dec,
    output logic            halted,
    output logic            fault,
    output logic [31:0]     fetch_count
);

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(MEM_DEPTH);
    localparam logic [PC_W-1:0] RST_PC   = PC_W'(RESET_PC);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     fcnt_q, fcnt_d;
    logic            push;
    logic            pop;
    logic            q_full;
    logic            q_empty;
    logic [1:0]      q_cnt;
    logic [31:0]     head_data;
    logic [PC_W-1:0] head_pc;

    assign pop = dec.inst_ready && (q_cnt != 2'd0);

    // Next state, next PC and push decision; redirect beats everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (redirect_valid) begin
            state_d = ST_RUN;
            pc_d    = redirect_pc;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pc_q >= DEPTH_PC) begin
                        state_d = ST_FAULT;
                    end else if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (!q_full || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 1'b1;
                    end
                end
                ST_HALT:  state_d = ST_HALT;
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RUN;
            endcase
        end
        fcnt_d = push ? fcnt_q + 32'd1 : fcnt_q;
    end

    // State, PC and fetch counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RST_PC;
            fcnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
        end
    end

    fetch_ctrl_queue #(
        .PC_W (PC_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i (mem_data),
        .push_pc_i   (pc_q),
        .head_data_o (head_data),
        .head_pc_o   (head_pc),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_cnt)
    );

    assign pc_out         = pc_q;
    assign dec.inst_valid = !q_empty;
    assign dec.inst_data  = q_empty ? 32'd0 : head_data;
    assign dec.inst_pc    = q_empty ? '0 : head_pc;
    assign halted         = (state_q == ST_HALT);
    assign fault          = (state_q == ST_FAULT);
    assign fetch_count    = fcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: ROM of A000_0000+i, queue-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    int tests;
    int fails;
    bit chk_en;

    fetch_ctrl_if #(.PC_W(32)) dif ();

    fetch_ctrl #(
        .PC_W      (32),
        .MEM_DEPTH (256),
        .RESET_PC  (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_out         (pc_out),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .dec            (dif),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a < 32'd256) ? 32'hA000_0000 + a : 32'd0;
    endfunction

    assign mem_data = rom(pc_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] pc_m;
    bit          halt_m;
    bit          fault_m;
    logic [31:0] fc_m;

    // Reference model: queue of {data,pc} advanced once per rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            pc_m    = 32'd0;
            halt_m  = 1'b0;
            fault_m = 1'b0;
            fc_m    = 32'd0;
            chk_en  = 1'b1;
        end else if (redirect_valid) begin
            mq.delete();
            pc_m    = redirect_pc;
            halt_m  = 1'b0;
            fault_m = 1'b0;
        end else begin
            if (mq.size() > 0 && dif.inst_ready) void'(mq.pop_front());
            if (!halt_m && !fault_m) begin
                if (pc_m >= 32'd256) fault_m = 1'b1;
                else if (halt_req) halt_m = 1'b1;
                else if (mq.size() < 2) begin
                    mq.push_back('{d: rom(pc_m), p: pc_m});
                    pc_m = pc_m + 1;
                    fc_m = fc_m + 1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", 32'(dif.inst_valid), 32'(mq.size() > 0));
            check("m_data", dif.inst_data, mq.size() > 0 ? mq[0].d : 32'd0);
            check("m_ipc", dif.inst_pc, mq.size() > 0 ? mq[0].p : 32'd0);
            check("m_pcout", pc_out, pc_m);
            check("m_halted", 32'(halted), 32'(halt_m));
            check("m_fault", 32'(fault), 32'(fault_m));
            check("m_fcount", fetch_count, fc_m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        tests          = 0;
        fails          = 0;
        chk_en         = 1'b0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt_req       = 1'b0;
        dif.inst_ready = 1'b0;
        step();
        step();

        // 1: streaming after reset release
        rst_n          = 1'b1;
        dif.inst_ready = 1'b1;
        check("t1_valid0", 32'(dif.inst_valid), 32'd0);
        check("t1_pcout0", pc_out, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_ipc", dif.inst_pc, 32'(i));
            check("t1_data", dif.inst_data, 32'hA000_0000 + 32'(i));
        end
        check("t1_fcount", fetch_count, 32'd4);

        // 2: backpressure for 5 cycles after reset
        rst_n          = 1'b0;
        dif.inst_ready = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("t2_ipc_hold", dif.inst_pc, 32'd0);
        check("t2_pcout", pc_out, 32'd2);
        dif.inst_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check("t2_ipc", dif.inst_pc, 32'(i));
        end

        // 3: redirect with full queue holding 3,4
        redirect_valid = 1'b1;
        redirect_pc    = 32'd20;
        step();
        redirect_valid = 1'b0;
        check("t3_gap", 32'(dif.inst_valid), 32'd0);
        check("t3_pcout", pc_out, 32'd20);
        step();
        check("t3_ipc", dif.inst_pc, 32'd20);
        check("t3_data", dif.inst_data, 32'hA000_0014);

        // 4: run off the end of the ROM, then recover
        redirect_valid = 1'b1;
        redirect_pc    = 32'd254;
        step();
        redirect_valid = 1'b0;
        step();
        check("t4_ipc254", dif.inst_pc, 32'd254);
        step();
        check("t4_ipc255", dif.inst_pc, 32'd255);
        step();
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_pcout", pc_out, 32'd256);
        check("t4_valid", 32'(dif.inst_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step();
        redirect_valid = 1'b0;
        check("t4_clr", 32'(fault), 32'd0);
        step();
        check("t4_resume", dif.inst_pc, 32'd0);

        // 5: halt with 7,8 queued, then redirect+halt together
        dif.inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd7;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_pcout", pc_out, 32'd9);
        check("t5_ipc7", dif.inst_pc, 32'd7);
        dif.inst_ready = 1'b1;
        step();
        check("t5_ipc8", dif.inst_pc, 32'd8);
        step();
        check("t5_drained", 32'(dif.inst_valid), 32'd0);
        check("t5_frozen", pc_out, 32'd9);
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd9;
        step();
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        check("t5_run", 32'(halted), 32'd0);
        step();
        check("t5_ipc9", dif.inst_pc, 32'd9);

        // 6: reset while full and faulted
        dif.inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd254;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        step();
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_full_ipc", dif.inst_pc, 32'd254);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_valid", 32'(dif.inst_valid), 32'd0);
        check("t6_fault0", 32'(fault), 32'd0);
        check("t6_pcout", pc_out, 32'd0);
        check("t6_fcount", fetch_count, 32'd0);
        check("t6_data", dif.inst_data, 32'd0);
        step();
        check("t6_first", dif.inst_pc, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
